bip_control: RTL and testbench
==============================

# bip_control

Multi-cycle control unit for the accumulator processor; it drives the existing accumulator datapath and both memories. It fetches 16-bit instructions from a synchronous program memory and decodes a 5-bit opcode and 11-bit operand. It then sequences the datapath selects (SelA, SelB, WrAcc, Op), the data-memory strobes and the program counter until a HLT instruction.

## Interface
- PC_W, 11, program counter / address width
- CNT_W, 16, cycle counter width
- clk  in  1  rising-edge clock
- Clear_n  in  1  reset, asynchronous assert, active-low
- Start  in  1  begin execution from address 0; sampled only in IDLE
- Instr  in  16  program memory read data; valid one cycle after Pc is presented
- Pc  out  PC_W  program memory address
- Addr  out  11  operand field IR[10:0] to the datapath sign extension and data memory address
- SelA  out  2  accumulator source: 0 ALU, 1 sign-extended Addr, 2 Out_Data
- SelB  out  1  ALU B operand: 0 sign-extended Addr, 1 Out_Data
- Op  out  1  ALU function: 1 add, 0 subtract
- WrAcc  out  1  accumulator write enable
- AccClear  out  1  datapath accumulator Clear
- RdRam  out  1  data memory read strobe; data valid the following cycle
- WrRam  out  1  data memory write strobe (write data is the datapath In_Data)
- Halted  out  1  HLT executed
- CycleCount  out  CNT_W  cycles spent in FETCH..WB

## Operation
- Opcodes are IR[15:11]:
  - HLT 00000, STO 00001, LD 00010, LDI 00011
  - ADD 00100, ADDI 00101, SUB 00110, SUBI 00111
  - All other opcodes execute as NOP.
- State machine, with states IDLE, FETCH, DECODE, MEM, WB, HALT:
  - IDLE: AccClear=1. On Start go to FETCH, with Pc=0 and CycleCount=0.
  - FETCH: Pc is stable. Go to DECODE.
  - DECODE: IR <= Instr at the end of the cycle. Next state by opcode:
    - STO, LD, ADD, SUB go to MEM.
    - LDI, ADDI, SUBI go to WB.
    - HLT goes to HALT.
    - NOP goes to FETCH, with Pc+1.
  - MEM:
    - STO: WrRam=1, then FETCH with Pc+1.
    - LD, ADD, SUB: RdRam=1, then WB.
  - WB: WrAcc=1 with SelA, SelB, Op set per opcode, then FETCH with Pc+1.
    - LD: SelA=2.
    - LDI: SelA=1.
    - ADD: SelA=0, SelB=1, Op=1.
    - ADDI: SelA=0, SelB=0, Op=1.
    - SUB: SelA=0, SelB=1, Op=0.
    - SUBI: SelA=0, SelB=0, Op=0.
  - HALT: Halted=1. Pc holds the HLT address. Start is ignored. Only Clear_n exits HALT.
- Strobes and counters:
  - WrAcc, RdRam and WrRam are 0 outside the states listed above.
  - SelA, SelB and Op are 0 when WrAcc=0.
- Addr always equals IR[10:0].
- Pc wraps from 2^PC_W-1 to 0.
- CycleCount increments in every non-IDLE, non-HALT cycle and saturates at all-ones.

## Timing
- Reset values:
  - State IDLE.
  - Pc=0, IR=0 (Addr=0), CycleCount=0.
  - All strobes 0, Halted=0.
  - AccClear=1, because the state is IDLE.
- Cycles per instruction:
  - STO 3, LD/ADD/SUB 4, immediates 3, NOP 2.
  - HLT takes 2 cycles to reach HALT.
- Control outputs are Moore-style decodes of state and IR. Pc, IR, state and CycleCount are registers.
- Clear_n asserted mid-instruction:
  - All outputs return to reset values immediately.
  - Any WrRam or WrAcc pulse in flight is cut; no partial-cycle guarantee is made.
- Start held high through HALT has no effect. Start asserted in the same cycle as a reset release is ignored.

## Structure
- Shared package bip_pkg holds:
  - opcode constants;
  - state encoding;
  - SelA codes (SEL_ALU, SEL_IMM, SEL_MEM) and SelB codes (SELB_IMM, SELB_MEM);
  - Op codes (OP_ADD, OP_SUB).
- One sub-module, program_counter: holds Pc with clear and increment inputs and PC_W-bit wrap.

## Test plan
- Reset, then Start pulse, with program LDI 5; ADDI -3 (operand 0x7FD); HLT:
  - WrAcc pulses in cycles 3 and 6 after Start, with SelA=1 then SelA=0/SelB=0/Op=1.
  - Halted=1 with Pc=2, CycleCount=8.
- STO 0x010 followed by LD 0x010:
  - WrRam with Addr=0x010 in the MEM cycle of STO.
  - In LD: RdRam in MEM, then WrAcc with SelA=2 the next cycle.
- SUB 0x003: RdRam=1, Addr=3, then WrAcc=1, SelA=0, SelB=1, Op=0; the instruction takes exactly 4 cycles.
- Opcode 11111: no strobes; Pc advances after 2 cycles.
- Pc wrap with PC_W=4 and NOPs at 0..15: Pc returns to 0 after address 15.
- Clear_n low during WB of ADD:
  - WrAcc drops asynchronously.
  - After release: IDLE, Pc=0, AccClear=1; execution restarts only on a new Start.

Source files
------------

// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcodes, state encoding and select codes for bip_control
package bip_pkg;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    localparam logic SELB_IMM = 1'b0;
    localparam logic SELB_MEM = 1'b1;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Where an opcode goes after DECODE; unknown opcodes fall through as NOP.
    function automatic state_t decode_target(input logic [4:0] opc);
        case (opc)
            OPC_STO, OPC_LD, OPC_ADD, OPC_SUB: return S_MEM;
            OPC_LDI, OPC_ADDI, OPC_SUBI:       return S_WB;
            OPC_HLT:                           return S_HALT;
            default:                           return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with clear, increment and natural wrap
module program_counter #(
    parameter int PC_W = 11
) (
    input  logic            clk,
    input  logic            Clear_n,
    input  logic            clear,
    input  logic            inc,
    output logic [PC_W-1:0] Pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Clear has priority over increment; the add wraps at 2^PC_W.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            Pc <= '0;
        end else if (clear) begin
            Pc <= '0;
        end else if (inc) begin
            Pc <= Pc + PC_ONE;
        end
    end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - multi-cycle control unit for the accumulator processor
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Clear_n,
    input  logic             Start,
    input  logic [15:0]      Instr,
    output logic [PC_W-1:0]  Pc,
    output logic [10:0]      Addr,
    output logic [1:0]       SelA,
    output logic             SelB,
    output logic             Op,
    output logic             WrAcc,
    output logic             AccClear,
    output logic             RdRam,
    output logic             WrRam,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_next;
    logic [15:0] ir;
    logic        armed;
    logic        start_ok;
    logic        pc_clear;
    logic        pc_inc;
    logic [4:0]  ir_opc;

    assign ir_opc = ir[15:11];
    assign Addr   = ir[10:0];
    // A Start coinciding with reset release is dropped: armed is still 0 on that edge.
    assign start_ok = Start && armed;

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk     (clk),
        .Clear_n (Clear_n),
        .clear   (pc_clear),
        .inc     (pc_inc),
        .Pc      (Pc)
    );

    // State, instruction register and the post-reset arm flag.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= S_IDLE;
            ir    <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (state == S_DECODE) begin
                ir <= Instr;
            end
        end
    end

    // Cycle counter: cleared on Start, counts active cycles, saturates at all-ones.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            CycleCount <= '0;
        end else if (state == S_IDLE) begin
            if (start_ok) begin
                CycleCount <= '0;
            end
        end else if (state != S_HALT && CycleCount != {CNT_W{1'b1}}) begin
            CycleCount <= CycleCount + CNT_ONE;
        end
    end

    // Next-state and Moore output decode from state and IR.
    always_comb begin
        state_next = state;
        pc_clear   = 1'b0;
        pc_inc     = 1'b0;
        SelA       = SEL_ALU;
        SelB       = SELB_IMM;
        Op         = OP_SUB;
        WrAcc      = 1'b0;
        RdRam      = 1'b0;
        WrRam      = 1'b0;
        AccClear   = 1'b0;
        Halted     = 1'b0;
        case (state)
            S_IDLE: begin
                AccClear = 1'b1;
                if (start_ok) begin
                    state_next = S_FETCH;
                    pc_clear   = 1'b1;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // IR is loaded on this edge, so decode straight from the memory output.
                state_next = decode_target(Instr[15:11]);
                if (decode_target(Instr[15:11]) == S_FETCH) begin
                    pc_inc = 1'b1;
                end
            end
            S_MEM: begin
                if (ir_opc == OPC_STO) begin
                    WrRam      = 1'b1;
                    state_next = S_FETCH;
                    pc_inc     = 1'b1;
                end else begin
                    RdRam      = 1'b1;
                    state_next = S_WB;
                end
            end
            S_WB: begin
                WrAcc      = 1'b1;
                state_next = S_FETCH;
                pc_inc     = 1'b1;
                case (ir_opc)
                    OPC_LD:   SelA = SEL_MEM;
                    OPC_LDI:  SelA = SEL_IMM;
                    OPC_ADD:  begin SelB = SELB_MEM; Op = OP_ADD; end
                    OPC_ADDI: begin SelB = SELB_IMM; Op = OP_ADD; end
                    OPC_SUB:  begin SelB = SELB_MEM; Op = OP_SUB; end
                    default:  begin SelB = SELB_IMM; Op = OP_SUB; end
                endcase
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// tb/tb_bip_control.sv - directed self-checking bench for bip_control
module tb_bip_control;

    logic        clk = 1'b0;
    logic        Clear_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [15:0] prog [0:2047];

    logic [10:0] pc, addr;
    logic [1:0]  sela;
    logic        selb, op, wracc, accclear, rdram, wrram, halted;
    logic [15:0] cyc;

    logic [15:0] instr4 = 16'hF800;
    logic [3:0]  pc4;
    logic [10:0] addr4;
    logic [1:0]  sela4;
    logic        selb4, op4, wracc4, accclear4, rdram4, wrram4, halted4;
    logic [3:0]  cyc4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) instr <= prog[pc];
    always @(posedge clk) instr4 <= 16'hF800;

    bip_control #(.PC_W(11), .CNT_W(16)) dut (
        .clk(clk), .Clear_n(Clear_n), .Start(Start), .Instr(instr),
        .Pc(pc), .Addr(addr), .SelA(sela), .SelB(selb), .Op(op),
        .WrAcc(wracc), .AccClear(accclear), .RdRam(rdram), .WrRam(wrram),
        .Halted(halted), .CycleCount(cyc)
    );

    bip_control #(.PC_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .Clear_n(Clear_n), .Start(Start), .Instr(instr4),
        .Pc(pc4), .Addr(addr4), .SelA(sela4), .SelB(selb4), .Op(op4),
        .WrAcc(wracc4), .AccClear(accclear4), .RdRam(rdram4), .WrRam(wrram4),
        .Halted(halted4), .CycleCount(cyc4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
        prog[0] = i0;
        prog[1] = i1;
        prog[2] = i2;
    endtask

    task automatic do_reset();
        Clear_n = 1'b0;
        Start   = 1'b0;
        tick(2);
        Clear_n = 1'b1;
        tick(1);
    endtask

    // Leaves the bench sampling cycle 1 (FETCH) after Start.
    task automatic do_start();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    initial begin
        // LDI 5; ADDI -3; HLT
        load(16'h1805, 16'h2FFD, 16'h0000);
        Clear_n = 1'b0;
        tick(2);
        check("rst_pc", pc, 0);
        check("rst_addr", addr, 0);
        check("rst_accclear", accclear, 1);
        check("rst_strobes", {wracc, rdram, wrram, halted}, 0);
        check("rst_cycles", cyc, 0);
        Clear_n = 1'b1;
        tick(1);
        do_start();
        check("ldi_fetch_accclear", accclear, 0);
        tick(2);
        check("ldi_wb", {wracc, sela, selb, op}, {1'b1, 2'd1, 1'b0, 1'b0});
        tick(3);
        check("addi_wb", {wracc, sela, selb, op}, {1'b1, 2'd0, 1'b0, 1'b1});
        check("addi_addr", addr, 11'h7FD);
        tick(3);
        check("hlt_halted", halted, 1);
        check("hlt_pc", pc, 2);
        check("hlt_cycles", cyc, 8);
        Start = 1'b1;
        tick(4);
        Start = 1'b0;
        check("halt_start_ignored", {halted, pc, cyc}, {1'b1, 11'd2, 16'd8});

        // STO 0x010; LD 0x010; HLT
        load(16'h0810, 16'h1010, 16'h0000);
        do_reset();
        do_start();
        tick(2);
        check("sto_mem", {wrram, rdram, wracc, addr}, {1'b1, 1'b0, 1'b0, 11'h010});
        tick(1);
        check("sto_next_pc", pc, 1);
        tick(2);
        check("ld_mem", {rdram, wrram, wracc}, {1'b1, 1'b0, 1'b0});
        tick(1);
        check("ld_wb", {wracc, sela, rdram}, {1'b1, 2'd2, 1'b0});

        // SUB 0x003; opcode 11111; HLT
        load(16'h3003, 16'hF800, 16'h0000);
        do_reset();
        do_start();
        tick(2);
        check("sub_mem", {rdram, addr}, {1'b1, 11'd3});
        tick(1);
        check("sub_wb", {wracc, sela, selb, op}, {1'b1, 2'd0, 1'b1, 1'b0});
        tick(1);
        check("sub_4cyc_pc", pc, 1);
        tick(1);
        check("nop_no_strobes", {wracc, rdram, wrram}, 0);
        tick(1);
        check("nop_2cyc_pc", pc, 2);
        tick(2);
        check("sub_halt", {halted, cyc}, {1'b1, 16'd8});

        // ADD 0x004 interrupted by Clear_n in WB
        load(16'h2004, 16'h0000, 16'h0000);
        do_reset();
        do_start();
        tick(3);
        check("add_wb", {wracc, sela, selb, op}, {1'b1, 2'd0, 1'b1, 1'b1});
        Clear_n = 1'b0;
        #1;
        check("clr_async", {wracc, accclear, pc}, {1'b1 ^ 1'b1, 1'b1, 11'd0});
        tick(1);
        Clear_n = 1'b1;
        Start   = 1'b1;
        tick(1);
        Start = 1'b0;
        check("clr_release_start", {accclear, pc, cyc}, {1'b1, 11'd0, 16'd0});
        tick(3);
        check("clr_idle_hold", {accclear, pc, wracc}, {1'b1, 11'd0, 1'b0});
        do_start();
        tick(3);
        check("add_restart_wb", {wracc, sela, selb, op}, {1'b1, 2'd0, 1'b1, 1'b1});

        // PC_W=4 all-NOP wrap and 4-bit cycle count saturation
        do_reset();
        do_start();
        check("wrap_pc0", pc4, 0);
        tick(2);
        check("wrap_pc1", pc4, 1);
        tick(28);
        check("wrap_pc15", pc4, 15);
        tick(2);
        check("wrap_pc_back0", pc4, 0);
        check("cnt_saturate", cyc4, 15);
        check("nop_outputs", {wracc4, rdram4, wrram4, sela4, selb4, op4, halted4, accclear4, addr4},
              {8'd0, 1'b0, 11'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
